traffic_fsm: RTL and testbench

TRAFFIC_FSM -- requirements
Module: traffic_fsm

---
 rtl/traffic_fsm.sv | 245 ++++++++++++++++++++++++
 tb/tb_traffic_fsm.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/traffic_fsm.sv
// -----------------------------------------------------------------------------
// traffic_fsm -- four-way traffic light phase controller
//
// The controller steps through these phases:
//    ALL_RED -> GREEN(d) -> [EXT_GREEN(d)] -> YELLOW(d) -> ALL_RED (d+1)
// A downstream timer paces it. The timer reads the registered phase code on
// `state` and returns a one-clock `expired` pulse when the current phase
// has run for its full time.
//
// State codes:
//    0 = ALL_RED; for direction d: 3d+1 GREEN, 3d+2 EXT_GREEN, 3d+3 YELLOW.
//    The logic never drives codes 13..15. If the state register ever holds
//    one of them, it returns to ALL_RED on the next clock.
//
// Parameters:
//    SETTLE_CYCLES  clocks after any state change during which `expired` is
//                   ignored (legal range 1..3). Default 1.
//
// Ports:
//    clk           system clock; all logic updates on the rising edge
//    rst           synchronous, active-high reset
//    expired       timer-expired pulse from the downstream timer
//    sensor[3:0]   vehicle-present flag per direction (bit d = direction d)
//    emergency     force-to-red request, level-sensitive
//    state[3:0]    registered phase code
//    lights[7:0]   2 bits per direction at [2d+1:2d]:
//                  00 red, 01 green, 10 yellow
//    phase_change  one-clock pulse in the cycle in which state shows a new value
//    dir[1:0]      current round-robin direction pointer
//
// Build option:
//    TRAFFIC_SKIP_EMPTY_EN  When this macro is defined, ALL_RED skips ahead to
//                           the first direction, starting at dir, whose sensor
//                           bit is set. Without the macro, the controller uses
//                           strict round-robin.
// -----------------------------------------------------------------------------
module traffic_fsm #(
   parameter int unsigned SETTLE_CYCLES = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       expired,
   input  logic [3:0] sensor,
   input  logic       emergency,
   output logic [3:0] state,
   output logic [7:0] lights,
   output logic       phase_change,
   output logic [1:0] dir
);

   // The settle counter only needs to hold values 0..3.
   localparam logic [1:0] SETTLE_INIT = 2'(SETTLE_CYCLES);

   typedef enum logic [3:0] {
      ALL_RED  = 4'd0,
      GREEN_0  = 4'd1,
      EXT_0    = 4'd2,
      YELLOW_0 = 4'd3,
      GREEN_1  = 4'd4,
      EXT_1    = 4'd5,
      YELLOW_1 = 4'd6,
      GREEN_2  = 4'd7,
      EXT_2    = 4'd8,
      YELLOW_2 = 4'd9,
      GREEN_3  = 4'd10,
      EXT_3    = 4'd11,
      YELLOW_3 = 4'd12
   } state_t;

   // Kind of phase, independent of direction. The encoding matches the
   // offset of the phase within its direction's group of three codes.
   typedef enum logic [1:0] {
      K_GREEN  = 2'd0,
      K_EXT    = 2'd1,
      K_YELLOW = 2'd2,
      K_RED    = 2'd3
   } kind_t;

   // Builds the state code for a (phase kind, direction) pair.
   // Callers pass only K_GREEN, K_EXT or K_YELLOW.
   function automatic state_t code_of(input kind_t k, input logic [1:0] d);
      logic [3:0] c;
      c = ({2'b00, d} * 4'd3) + {2'b00, k} + 4'd1;
      return state_t'(c);
   endfunction

   state_t     state_reg, state_next;
   logic [1:0] dir_reg, dir_next;
   logic [1:0] settle_reg;
   logic       phase_change_reg;

   logic       qualified;
   logic       changed;
   logic [1:0] target_dir;

   // Decoded view of the registered state
   kind_t      cur_kind;
   logic [1:0] cur_dir;
   logic       cur_legal;
   logic [3:0] code_idx;

   // -------------------------------------------------------------------------
   // Split the registered code into (kind, direction). The lights decode
   // from this view, so they follow only the state register and never the
   // raw inputs.
   // -------------------------------------------------------------------------
   always_comb begin
      cur_kind  = K_RED;
      cur_dir   = 2'd0;
      cur_legal = 1'b1;
      code_idx  = 4'd0;
      if (state_reg == ALL_RED) begin
         cur_kind = K_RED;
      end else if (state_reg <= YELLOW_3) begin
         code_idx = state_reg - 4'd1;
         cur_dir  = 2'(code_idx / 4'd3);
         cur_kind = kind_t'(2'(code_idx % 4'd3));
      end else begin
         cur_legal = 1'b0;
      end
   end

   // -------------------------------------------------------------------------
   // Target direction for the next GREEN after ALL_RED
   // -------------------------------------------------------------------------
`ifdef TRAFFIC_SKIP_EMPTY_EN
   // sensor_rot[i] is the sensor of direction dir+i. Scanning it from bit 0
   // upward therefore searches the directions in round-robin order,
   // starting at dir.
   logic [3:0] sensor_rot;
   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_rot
         assign sensor_rot[gi] = sensor[dir_reg + 2'(gi)];
      end
   endgenerate

   always_comb begin
      target_dir = dir_reg;
      if (sensor_rot[0]) begin
         target_dir = dir_reg;
      end else if (sensor_rot[1]) begin
         target_dir = dir_reg + 2'd1;
      end else if (sensor_rot[2]) begin
         target_dir = dir_reg + 2'd2;
      end else if (sensor_rot[3]) begin
         target_dir = dir_reg + 2'd3;
      end
   end
`else
   assign target_dir = dir_reg;
`endif

   // -------------------------------------------------------------------------
   // Next-state logic
   // -------------------------------------------------------------------------
   assign qualified = expired && (settle_reg == 2'd0);

   always_comb begin
      state_next = state_reg;
      dir_next   = dir_reg;
      if (!cur_legal) begin
         state_next = ALL_RED;
      end else begin
         case (cur_kind)
            K_RED: begin
               // While emergency is high, the junction stays all-red.
               if (qualified && !emergency) begin
                  state_next = code_of(K_GREEN, target_dir);
                  dir_next   = target_dir;
               end
            end
            K_GREEN: begin
               // Emergency takes priority over extension, even when a
               // qualified expired arrives in the same clock.
               if (emergency) begin
                  state_next = code_of(K_YELLOW, dir_reg);
               end else if (qualified) begin
                  state_next = sensor[dir_reg] ? code_of(K_EXT, dir_reg)
                                               : code_of(K_YELLOW, dir_reg);
               end
            end
            K_EXT: begin
               // Only YELLOW follows EXT_GREEN, so a GREEN can be extended
               // at most once.
               if (emergency || qualified) begin
                  state_next = code_of(K_YELLOW, dir_reg);
               end
            end
            K_YELLOW: begin
               // The yellow phase always runs to completion, even during an
               // emergency.
               if (qualified) begin
                  state_next = ALL_RED;
                  dir_next   = dir_reg + 2'd1;
               end
            end
            default: begin
               state_next = ALL_RED;
            end
         endcase
      end
   end

   assign changed = (state_next != state_reg);

   // -------------------------------------------------------------------------
   // State, direction, settle counter and phase_change registers
   // -------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg        <= ALL_RED;
         dir_reg          <= 2'd0;
         settle_reg       <= SETTLE_INIT;
         phase_change_reg <= 1'b0;
      end else begin
         state_reg        <= state_next;
         dir_reg          <= dir_next;
         phase_change_reg <= changed;
         if (changed) begin
            settle_reg <= SETTLE_INIT;
         end else if (settle_reg != 2'd0) begin
            settle_reg <= settle_reg - 2'd1;
         end
      end
   end

   // -------------------------------------------------------------------------
   // Lights: at most one direction can match cur_dir, so at most one
   // direction is non-red at any time.
   // -------------------------------------------------------------------------
   genvar li;
   generate
      for (li = 0; li < 4; li++) begin : g_lights
         assign lights[2*li+1 : 2*li] =
            (cur_kind == K_RED || cur_dir != 2'(li)) ? 2'b00 :
            (cur_kind == K_YELLOW)                   ? 2'b10 : 2'b01;
      end
   endgenerate

   assign state        = state_reg;
   assign dir          = dir_reg;
   assign phase_change = phase_change_reg;

endmodule

// File: tb/tb_traffic_fsm.sv
// -----------------------------------------------------------------------------
// tb_traffic_fsm -- directed testbench for traffic_fsm.
//
// The bench contains two instances that share all inputs:
//    dut   uses the default SETTLE_CYCLES (1)
//    dut2  uses SETTLE_CYCLES = 2
// Each test task drives inputs one clock at a time. It compares outputs
// 1 time unit after the rising edge against hand-computed constants.
// -----------------------------------------------------------------------------
module tb_traffic_fsm;

   logic       clk = 1'b0;
   logic       rst;
   logic       expired;
   logic       emergency;
   logic [3:0] sensor;

   logic [3:0] st, st2;
   logic [7:0] lt, lt2;
   logic       pc, pc2;
   logic [1:0] dr, dr2;

   int checks   = 0;
   int failures = 0;

   traffic_fsm dut (
      .clk          (clk),
      .rst          (rst),
      .expired      (expired),
      .sensor       (sensor),
      .emergency    (emergency),
      .state        (st),
      .lights       (lt),
      .phase_change (pc),
      .dir          (dr)
   );

   traffic_fsm #(.SETTLE_CYCLES(2)) dut2 (
      .clk          (clk),
      .rst          (rst),
      .expired      (expired),
      .sensor       (sensor),
      .emergency    (emergency),
      .state        (st2),
      .lights       (lt2),
      .phase_change (pc2),
      .dir          (dr2)
   );

   always #5 clk = ~clk;

   // Expected values after each of 13 expired pulses with all sensors low.
   logic [3:0] rr_state  [13] = '{4'd1, 4'd3, 4'd0, 4'd4, 4'd6, 4'd0, 4'd7,
                                  4'd9, 4'd0, 4'd10, 4'd12, 4'd0, 4'd1};
   logic [1:0] rr_dir    [13] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd2, 2'd2,
                                  2'd2, 2'd3, 2'd3, 2'd3, 2'd0, 2'd0};
   logic [7:0] rr_lights [13] = '{8'h01, 8'h02, 8'h00, 8'h04, 8'h08, 8'h00,
                                  8'h10, 8'h20, 8'h00, 8'h40, 8'h80, 8'h00,
                                  8'h01};

   // Expired held high from tick 1 onward.
   // dut (SETTLE_CYCLES=1) advances every 2 clocks.
   // dut2 (SETTLE_CYCLES=2) advances every 3 clocks.
   logic [3:0] s1_state [10] = '{4'd1, 4'd1, 4'd3, 4'd3, 4'd0, 4'd0, 4'd4,
                                 4'd4, 4'd6, 4'd6};
   logic [3:0] s2_state [10] = '{4'd1, 4'd1, 4'd1, 4'd3, 4'd3, 4'd3, 4'd0,
                                 4'd0, 4'd0, 4'd4};

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) tick();
   endtask

   // Nine quiet clocks, then a single-clock expired pulse.
   task automatic pulse();
      idle(9);
      expired = 1'b1;
      tick();
      expired = 1'b0;
   endtask

   task automatic do_reset();
      rst       = 1'b1;
      expired   = 1'b0;
      emergency = 1'b0;
      sensor    = 4'b0000;
      tick();
      rst = 1'b0;
   endtask

   // -------------------------------------------------------------------------
   task automatic test_reset();
      do_reset();
      checks++; if (st !== 4'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", st); end
      checks++; if (dr !== 2'd0) begin failures++; $display("FAIL reset_dir got=%0d exp=0", dr); end
      checks++; if (lt !== 8'h00) begin failures++; $display("FAIL reset_lights got=%h exp=00", lt); end
      checks++; if (pc !== 1'b0) begin failures++; $display("FAIL reset_phase_change got=%b exp=0", pc); end
      $display("test_reset: state=%0d dir=%0d lights=%h", st, dr, lt);
   endtask

   task automatic test_round_robin();
      for (int i = 0; i < 13; i++) begin
         pulse();
         checks++; if (st !== rr_state[i]) begin failures++; $display("FAIL rr_state[%0d] got=%0d exp=%0d", i, st, rr_state[i]); end
         checks++; if (dr !== rr_dir[i]) begin failures++; $display("FAIL rr_dir[%0d] got=%0d exp=%0d", i, dr, rr_dir[i]); end
         checks++; if (lt !== rr_lights[i]) begin failures++; $display("FAIL rr_lights[%0d] got=%h exp=%h", i, lt, rr_lights[i]); end
         checks++; if (pc !== 1'b1) begin failures++; $display("FAIL rr_phase_change[%0d] got=%b exp=1", i, pc); end
         $display("test_round_robin: pulse %0d state=%0d dir=%0d lights=%h", i, st, dr, lt);
      end
      tick();
      checks++; if (pc !== 1'b0) begin failures++; $display("FAIL rr_phase_change_drop got=%b exp=0", pc); end
      checks++; if (st !== 4'd1) begin failures++; $display("FAIL rr_hold got=%0d exp=1", st); end
   endtask

   // The previous test leaves the DUT in GREEN of direction 0.
   task automatic test_extension();
      sensor = 4'b0001;
      pulse();
      checks++; if (st !== 4'd2) begin failures++; $display("FAIL ext_state got=%0d exp=2", st); end
      checks++; if (lt !== 8'b00000001) begin failures++; $display("FAIL ext_lights got=%b exp=00000001", lt); end
      $display("test_extension: state=%0d lights=%b", st, lt);
      pulse();
      checks++; if (st !== 4'd3) begin failures++; $display("FAIL ext_yellow got=%0d exp=3", st); end
      checks++; if (lt !== 8'b00000010) begin failures++; $display("FAIL ext_yellow_lights got=%b exp=00000010", lt); end
      $display("test_extension: state=%0d lights=%b", st, lt);
      sensor = 4'b0000;
      pulse();
      checks++; if (st !== 4'd0 || dr !== 2'd1) begin failures++; $display("FAIL ext_allred got=%0d/%0d exp=0/1", st, dr); end
   endtask

   // Starts in ALL_RED with dir=1.
   task automatic test_emergency();
      sensor = 4'b0010;
      pulse();
      pulse();
      checks++; if (st !== 4'd5) begin failures++; $display("FAIL emg_pre got=%0d exp=5", st); end
      emergency = 1'b1;
      tick();
      checks++; if (st !== 4'd6) begin failures++; $display("FAIL emg_to_yellow got=%0d exp=6", st); end
      checks++; if (pc !== 1'b1) begin failures++; $display("FAIL emg_phase_change got=%b exp=1", pc); end
      tick();
      checks++; if (st !== 4'd6) begin failures++; $display("FAIL emg_yellow_wait got=%0d exp=6", st); end
      pulse();
      checks++; if (st !== 4'd0 || dr !== 2'd2) begin failures++; $display("FAIL emg_allred got=%0d/%0d exp=0/2", st, dr); end
      pulse();
      checks++; if (st !== 4'd0) begin failures++; $display("FAIL emg_hold got=%0d exp=0", st); end
      checks++; if (lt !== 8'h00) begin failures++; $display("FAIL emg_hold_lights got=%h exp=00", lt); end
      $display("test_emergency: state=%0d dir=%0d", st, dr);
      emergency = 1'b0;
      sensor    = 4'b0000;
      pulse();
      checks++; if (st !== 4'd7) begin failures++; $display("FAIL emg_release got=%0d exp=7", st); end
   endtask

   // Starts in GREEN of direction 2.
   task automatic test_priority();
      sensor = 4'b0100;
      idle(3);
      expired   = 1'b1;
      emergency = 1'b1;
      tick();
      expired   = 1'b0;
      emergency = 1'b0;
      sensor    = 4'b0000;
      checks++; if (st !== 4'd9) begin failures++; $display("FAIL prio_state got=%0d exp=9", st); end
      checks++; if (lt !== 8'h20) begin failures++; $display("FAIL prio_lights got=%h exp=20", lt); end
      pulse();
      pulse();
      checks++; if (st !== 4'd10 || dr !== 2'd3) begin failures++; $display("FAIL prio_green3 got=%0d/%0d exp=10/3", st, dr); end
      emergency = 1'b1;
      tick();
      emergency = 1'b0;
      checks++; if (st !== 4'd12) begin failures++; $display("FAIL prio_emg_green got=%0d exp=12", st); end
      pulse();
      checks++; if (st !== 4'd0 || dr !== 2'd0) begin failures++; $display("FAIL prio_wrap got=%0d/%0d exp=0/0", st, dr); end
      $display("test_priority: state=%0d dir=%0d", st, dr);
   endtask

   task automatic test_settle();
      do_reset();
      idle(5);
      expired = 1'b1;
      for (int t = 0; t < 10; t++) begin
         tick();
         checks++; if (st !== s1_state[t]) begin failures++; $display("FAIL settle1_state[%0d] got=%0d exp=%0d", t, st, s1_state[t]); end
         checks++; if (pc !== ((t % 2) == 0)) begin failures++; $display("FAIL settle1_pc[%0d] got=%b exp=%b", t, pc, (t % 2) == 0); end
         checks++; if (st2 !== s2_state[t]) begin failures++; $display("FAIL settle2_state[%0d] got=%0d exp=%0d", t, st2, s2_state[t]); end
         checks++; if (pc2 !== ((t % 3) == 0)) begin failures++; $display("FAIL settle2_pc[%0d] got=%b exp=%b", t, pc2, (t % 3) == 0); end
         $display("test_settle: tick %0d s1=%0d s2=%0d", t, st, st2);
      end
      expired = 1'b0;
      checks++; if (dr2 !== 2'd1 || lt2 !== 8'h04) begin failures++; $display("FAIL settle2_end got=%0d/%h exp=1/04", dr2, lt2); end
   endtask

   task automatic test_reset_mid();
      do_reset();
      for (int i = 0; i < 7; i++) pulse();
      sensor = 4'b0100;
      pulse();
      checks++; if (st !== 4'd8) begin failures++; $display("FAIL rstmid_pre got=%0d exp=8", st); end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checks++; if (st !== 4'd0) begin failures++; $display("FAIL rstmid_state got=%0d exp=0", st); end
      checks++; if (dr !== 2'd0) begin failures++; $display("FAIL rstmid_dir got=%0d exp=0", dr); end
      checks++; if (lt !== 8'h00) begin failures++; $display("FAIL rstmid_lights got=%h exp=00", lt); end
      checks++; if (pc !== 1'b0) begin failures++; $display("FAIL rstmid_pc got=%b exp=0", pc); end
      tick();
      checks++; if (st !== 4'd0) begin failures++; $display("FAIL rstmid_no_yellow got=%0d exp=0", st); end
      sensor = 4'b0000;
      pulse();
      checks++; if (st !== 4'd1 || dr !== 2'd0) begin failures++; $display("FAIL rstmid_first got=%0d/%0d exp=1/0", st, dr); end
      $display("test_reset_mid: state=%0d dir=%0d", st, dr);
   endtask

   task automatic test_skip();
      do_reset();
      for (int i = 0; i < 3; i++) pulse();
      sensor = 4'b1000;
      pulse();
`ifdef TRAFFIC_SKIP_EMPTY_EN
      checks++; if (st !== 4'd10 || dr !== 2'd3) begin failures++; $display("FAIL skip_target got=%0d/%0d exp=10/3", st, dr); end
`else
      checks++; if (st !== 4'd4 || dr !== 2'd1) begin failures++; $display("FAIL noskip_target got=%0d/%0d exp=4/1", st, dr); end
`endif
      $display("test_skip: sensor=1000 state=%0d dir=%0d", st, dr);
      do_reset();
      for (int i = 0; i < 3; i++) pulse();
      pulse();
      checks++; if (st !== 4'd4 || dr !== 2'd1) begin failures++; $display("FAIL skip_empty got=%0d/%0d exp=4/1", st, dr); end
      $display("test_skip: sensor=0000 state=%0d dir=%0d", st, dr);
   endtask

   initial begin
      rst       = 1'b1;
      expired   = 1'b0;
      emergency = 1'b0;
      sensor    = 4'b0000;
      test_reset();
      test_round_robin();
      test_extension();
      test_emergency();
      test_priority();
      test_settle();
      test_reset_mid();
      test_skip();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog time limit reached checks=%0d", checks);
      $fatal(1, "watchdog");
   end

endmodule
